// File: rtl/s5s_dpr_pkg.sv
// Shared types and constants for the s5s DPR responder.
package s5s_dpr_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    CmdNop   = 2'd0,
    CmdRd    = 2'd1,
    CmdWr    = 2'd2,
    CmdFlush = 2'd3
  } t_dpr_cmd;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } t_resp_state;

  // Counter load value: a latency of N cycles counts N-1 down to zero.
  function automatic logic [LAT_W-1:0] lat_load(input int unsigned lat);
    return LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/s5s_dpr_lat_cnt.sv
// Load/decrement/hold down-counter with a zero flag, used for response latency.
module s5s_dpr_lat_cnt
  import s5s_dpr_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - LAT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/s5s_dpr_resp.sv
// s5s DPR responder: req/rdy handshake with per-command latency, counters and sticky err.
// Optional S5S_DPR_RESP_STALL_EN adds an i_stall input that freezes the countdown.
module s5s_dpr_resp
  import s5s_dpr_pkg::*;
#(
  parameter int unsigned LAT_NOP   = 1,
  parameter int unsigned LAT_RD    = 4,
  parameter int unsigned LAT_WR    = 2,
  parameter int unsigned LAT_FLUSH = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef S5S_DPR_RESP_STALL_EN
  input  logic             i_stall,
`endif
  input  logic             i_req,
  input  logic [1:0]       i_cmd,
  output logic             o_rdy,
  output logic             o_busy,
  output logic [1:0]       o_cur_cmd,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt_rd,
  output logic [CNT_W-1:0] o_cnt_wr
);

  t_resp_state      r_state, w_state_nxt;
  t_dpr_cmd         r_cur_cmd;
  logic             r_rdy, r_busy, r_err;
  logic [CNT_W-1:0] r_cnt_rd, r_cnt_wr;
  logic             w_stall, w_accept, w_done, w_dec, w_lat_zero;
  logic [LAT_W-1:0] w_load_val;

`ifdef S5S_DPR_RESP_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_dec       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req) begin
          w_accept    = 1'b1;
          w_state_nxt = StBusy;
        end
      end
      StBusy: begin
        if (!w_stall) begin
          if (w_lat_zero) begin
            w_done      = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_load_val = '0;
    case (t_dpr_cmd'(i_cmd))
      CmdNop:   w_load_val = lat_load(LAT_NOP);
      CmdRd:    w_load_val = lat_load(LAT_RD);
      CmdWr:    w_load_val = lat_load(LAT_WR);
      CmdFlush: w_load_val = lat_load(LAT_FLUSH);
      default:  w_load_val = '0;
    endcase
  end

  s5s_dpr_lat_cnt u_lat_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_lat_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_cmd <= CmdNop;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt_rd  <= '0;
      r_cnt_wr  <= '0;
    end else begin
      r_rdy  <= w_done;
      // Lags the state by one cycle so it covers the rdy cycle but not the accept cycle.
      r_busy <= (r_state == StBusy);
      if (w_accept) begin
        r_cur_cmd <= t_dpr_cmd'(i_cmd);
      end
      if (i_req && (r_state == StBusy)) begin
        r_err <= 1'b1;
      end
      if (w_done && (r_cur_cmd == CmdRd) && (r_cnt_rd != '1)) begin
        r_cnt_rd <= r_cnt_rd + CNT_W'(1);
      end
      if (w_done && (r_cur_cmd == CmdWr) && (r_cnt_wr != '1)) begin
        r_cnt_wr <= r_cnt_wr + CNT_W'(1);
      end
    end
  end

  assign o_rdy     = r_rdy;
  assign o_busy    = r_busy;
  assign o_cur_cmd = r_cur_cmd;
  assign o_err     = r_err;
  assign o_cnt_rd  = r_cnt_rd;
  assign o_cnt_wr  = r_cnt_wr;

endmodule
